// File: rtl/serial_comparator_32b_rtl.sv
// Byte-serial 32-bit comparator: MSB byte first, stops at the first differing byte.
// Accept-to-result 2..5 cycles; result held in DONE while ostream_rdy=0, no new request accepted.
module serial_comparator_32b_rtl (
  input  logic        clk,
  input  logic        reset,
  input  logic        istream_val,
  output logic        istream_rdy,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        is_signed,
  output logic        ostream_val,
  input  logic        ostream_rdy,
  output logic        eq,
  output logic        lt
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        eq_q, eq_d, lt_q, lt_d;
  logic [7:0]  a_byte, b_byte;

  always_comb begin
    a_byte = a_q[31:24];
    b_byte = b_q[31:24];
    case (k_q)
      2'd0: begin a_byte = a_q[31:24]; b_byte = b_q[31:24]; end
      2'd1: begin a_byte = a_q[23:16]; b_byte = b_q[23:16]; end
      2'd2: begin a_byte = a_q[15:8];  b_byte = b_q[15:8];  end
      default: begin a_byte = a_q[7:0]; b_byte = b_q[7:0]; end
    endcase
  end

  // Handshake outputs are gated by reset so nothing is offered while it is held.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    eq_d        = eq_q;
    lt_d        = lt_q;
    istream_rdy = (state_q == IDLE) && !reset;
    ostream_val = (state_q == DONE) && !reset;

    case (state_q)
      IDLE: begin
        if (istream_val && istream_rdy) begin
          a_d     = in0;
          b_d     = in1;
          sgn_d   = is_signed;
          k_d     = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (a_byte != b_byte) begin
          eq_d = 1'b0;
          // Only the top byte carries the sign; mismatched signs decide outright.
          if ((k_q == 2'd0) && sgn_q && (a_q[31] != b_q[31])) lt_d = a_q[31];
          else                                                lt_d = (a_byte < b_byte);
          state_d = DONE;
        end else if (k_q == 2'd3) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      DONE: begin
        if (ostream_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign eq = eq_q;
  assign lt = lt_q;

endmodule
